// File: rtl/decrypt_and_receive.sv
// Serial receiver: XOR-decrypts one bit per cycle and assembles WORDS 4-bit words into a readable store.
// Define FRAME_ERR_EN to add the frame_err pulse output for short and over-length frames.
module decrypt_and_receive #(
    parameter int unsigned WORDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_in,
    input  logic       key,
    input  logic       data_enc,
    input  logic [3:0] rd_addr,
    output logic [3:0] data_out,
    output logic       done,
    output logic       busy
`ifdef FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int unsigned   AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned   CW       = 6;
    localparam logic [CW-1:0] LAST_BIT = CW'(4 * WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_bit_cnt;
    // Three most recent plain bits; the fourth bit of a word is the plain bit of the writing cycle.
    logic [2:0]    r_shift;
    logic          r_wait_low;
    logic          w_wait_low_nxt;
    logic          w_accept;
    logic          w_clear;
    logic          w_plain;
    logic          w_last;
    logic          w_word_wr;
    logic [3:0]    w_word;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_rd_ok;
    logic [3:0]    r_store [WORDS];
    logic [3:0]    r_data_out;
    logic          r_done;
    logic          r_busy;

    assign w_plain   = data_enc ^ key;
    assign w_last    = (r_bit_cnt == LAST_BIT);
    assign w_word    = {r_shift, w_plain};
    assign w_word_wr = w_accept && (r_bit_cnt[1:0] == 2'b11);
    assign w_wr_idx  = AW'(r_bit_cnt[5:2]);
    assign w_rd_idx  = AW'(rd_addr);
    assign w_rd_ok   = (32'(rd_addr) < WORDS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_clear        = 1'b0;
        w_wait_low_nxt = r_wait_low;
        case (r_state)
            IDLE: begin
                if (r_wait_low) begin
                    if (!ena_in) begin
                        w_wait_low_nxt = 1'b0;
                    end
                end else if (ena_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                if (ena_in) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_clear     = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_clear     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (ena_in) begin
                    w_wait_low_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // Datapath, word store and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_wait_low <= ena_in;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
            for (int i = 0; i < int'(WORDS); i++) begin
                r_store[i] <= '0;
            end
        end else begin
            r_wait_low <= w_wait_low_nxt;
            r_done     <= (w_state_nxt == DONE);
            r_busy     <= (w_state_nxt == RECV);
            if (w_clear) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
                r_shift   <= {r_shift[1:0], w_plain};
            end
            if (w_word_wr) begin
                r_store[w_wr_idx] <= w_word;
            end
            // Nonblocking read of the store returns pre-write data on a same-address collision.
            r_data_out <= w_rd_ok ? r_store[w_rd_idx] : 4'h0;
        end
    end

    assign data_out = r_data_out;
    assign done     = r_done;
    assign busy     = r_busy;

`ifdef FRAME_ERR_EN
    logic w_err;
    logic r_frame_err;

    // Early drop while receiving, or first bit arriving during the DONE cycle.
    assign w_err = ((r_state == RECV) && !ena_in) || ((r_state == DONE) && ena_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_decrypt_and_receive.sv
// Bench for decrypt_and_receive: WORDS=16 and WORDS=4 instances share stimulus; frame-level store model.
module tb_decrypt_and_receive;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena_in;
    logic       key;
    logic       data_enc;
    logic [3:0] rd_addr;
    logic [3:0] dout16;
    logic [3:0] dout4;
    logic       done16;
    logic       done4;
    logic       busy16;
    logic       busy4;
`ifdef FRAME_ERR_EN
    logic       ferr16;
    logic       ferr4;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] wv    [20];
    logic       kb    [80];
    logic [3:0] exp16 [16];
    logic [3:0] exp4  [4];

    always #5 clk = ~clk;

    decrypt_and_receive #(.WORDS(16)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .ena_in   (ena_in),
        .key      (key),
        .data_enc (data_enc),
        .rd_addr  (rd_addr),
        .data_out (dout16),
        .done     (done16),
        .busy     (busy16)
`ifdef FRAME_ERR_EN
        ,
        .frame_err(ferr16)
`endif
    );

    decrypt_and_receive #(.WORDS(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .ena_in   (ena_in),
        .key      (key),
        .data_enc (data_enc),
        .rd_addr  (rd_addr),
        .data_out (dout4),
        .done     (done4),
        .busy     (busy4)
`ifdef FRAME_ERR_EN
        ,
        .frame_err(ferr4)
`endif
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic plain_bit(input int k);
        logic [3:0] w;
        w = wv[k / 4];
        return w[3 - (k % 4)];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp16[i] = 4'h0;
        for (int i = 0; i < 4; i++)  exp4[i]  = 4'h0;
    endtask

    task automatic fill_random(input bit rand_key, input logic key_val);
        for (int i = 0; i < 20; i++) wv[i] = 4'($urandom_range(0, 15));
        for (int k = 0; k < 80; k++) kb[k] = rand_key ? 1'($urandom) : key_val;
    endtask

    task automatic drive_bit(input int k);
        @(negedge clk);
        ena_in   = 1'b1;
        key      = kb[k];
        data_enc = plain_bit(k) ^ kb[k];
        @(posedge clk);
        #1;
    endtask

    // Drive nbits frame bits, then one low cycle; check handshake each cycle and update the store model.
    task automatic run_frame(input int nbits);
        int n;
        for (int k = 0; k < nbits; k++) begin
            drive_bit(k);
            chk1("done16", done16, k == 63);
            chk1("busy16", busy16, k < 63);
            chk1("done4",  done4,  k == 15);
            chk1("busy4",  busy4,  k < 15);
`ifdef FRAME_ERR_EN
            chk1("ferr16", ferr16, k == 64);
            chk1("ferr4",  ferr4,  k == 16);
`endif
        end
        @(negedge clk);
        ena_in   = 1'b0;
        key      = 1'($urandom);
        data_enc = 1'($urandom);
        @(posedge clk);
        #1;
        chk1("done16_end", done16, 1'b0);
        chk1("busy16_end", busy16, 1'b0);
        chk1("done4_end",  done4,  1'b0);
        chk1("busy4_end",  busy4,  1'b0);
`ifdef FRAME_ERR_EN
        chk1("ferr16_end", ferr16, nbits < 64);
        chk1("ferr4_end",  ferr4,  nbits < 16);
`endif
        n = ((nbits < 64) ? nbits : 64) / 4;
        for (int i = 0; i < n; i++) exp16[i] = wv[i];
        n = ((nbits < 16) ? nbits : 16) / 4;
        for (int i = 0; i < n; i++) exp4[i] = wv[i];
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rd_addr = 4'(a);
            @(posedge clk);
            #1;
            chk4("rd16", dout16, exp16[a]);
            if (a < 4) chk4("rd4", dout4, exp4[a]);
            else       chk4("rd4_oob", dout4, 4'h0);
        end
    endtask

    task automatic do_reset(input logic ena_level);
        @(negedge clk);
        rst    = 1'b1;
        ena_in = ena_level;
        @(posedge clk);
        #1;
        chk1("rst_busy16", busy16, 1'b0);
        chk1("rst_done16", done16, 1'b0);
        chk4("rst_dout16", dout16, 4'h0);
        chk1("rst_busy4",  busy4,  1'b0);
        chk1("rst_done4",  done4,  1'b0);
        chk4("rst_dout4",  dout4,  4'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        rst      = 1'b1;
        ena_in   = 1'b0;
        key      = 1'b0;
        data_enc = 1'b0;
        rd_addr  = 4'h0;
        clear_model();
        repeat (2) @(posedge clk);
        do_reset(1'b0);
        read_all();

        // Words 0..F with key 0; done in the cycle after bit 63, address 5 reads 5.
        fill_random(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) wv[i] = 4'(i);
        run_frame(64);
        @(negedge clk);
        rd_addr = 4'h5;
        @(posedge clk);
        #1;
        chk4("rd16_addr5", dout16, 4'h5);
        read_all();

        // Key held at 1 with inverted ciphertext.
        fill_random(1'b0, 1'b1);
        wv[0] = 4'hA;
        wv[1] = 4'h5;
        run_frame(64);
        read_all();

        // Early drop after 10 bits from a clean store.
        do_reset(1'b0);
        fill_random(1'b1, 1'b0);
        run_frame(10);
        read_all();

        // Over-length frame of 70 bits.
        fill_random(1'b1, 1'b0);
        run_frame(70);
        read_all();

        // Random lengths and per-bit keys.
        for (int f = 0; f < 6; f++) begin
            fill_random(1'b1, 1'b0);
            run_frame($urandom_range(1, 72));
            read_all();
        end

        // Reset at bit 30 with ena_in held high through and after reset.
        fill_random(1'b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            drive_bit(k);
            chk1("busy16_pre", busy16, 1'b1);
        end
        do_reset(1'b1);
        for (int k = 30; k < 34; k++) begin
            drive_bit(k);
            chk1("busy16_hold", busy16, 1'b0);
            chk1("busy4_hold",  busy4,  1'b0);
            chk1("done16_hold", done16, 1'b0);
        end
        @(negedge clk);
        ena_in = 1'b0;
        read_all();

        // Short frame 1,2,3,4: completes the WORDS=4 instance only.
        fill_random(1'b0, 1'b0);
        wv[0] = 4'h1;
        wv[1] = 4'h2;
        wv[2] = 4'h3;
        wv[3] = 4'h4;
        run_frame(16);
        read_all();

        fill_random(1'b1, 1'b0);
        run_frame(64);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/decrypt_and_receive.md
DECRYPT_AND_RECEIVE -- requirements
Module: decrypt_and_receive

Interface
REQ-001 SHALL have parameter: WORDS, default 16, number of 4-bit words per frame (legal 1..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port: ena_in  input  1  frame-valid strobe from the upstream transmitter; one serial bit per cycle while high.
REQ-005 SHALL have port: key  input  1  decryption key bit, XORed with every received bit.
REQ-006 SHALL have port: data_enc  input  1  encrypted serial data.
REQ-007 SHALL have port: rd_addr  input  4  read address into the received-word store.
REQ-008 SHALL have port: data_out  output  4  registered read data.
REQ-009 SHALL have port: done  output  1  one-cycle pulse: complete frame stored.
REQ-010 SHALL have port: busy  output  1  high while in RECV.

Function
REQ-011 SHALL decrypt each bit as plain = data_enc ^ key, sampled on the same edge as ena_in.
REQ-012 SHALL use frame format: words in address order 0..WORDS-1, each word MSB first, 4*WORDS bits total, ena_in continuously high.
REQ-013 SHALL implement FSM states IDLE, RECV, DONE.
REQ-014 SHALL transition IDLE->RECV on the first cycle with ena_in=1; that cycle's bit is bit 0 of the frame.
REQ-015 SHALL maintain a 6-bit bit counter and a 4-bit shift register; the shift register shifts left, inserting the plain bit at LSB.
REQ-016 SHALL write the completed word {shift[2:0], plain} to store[bit_cnt[5:2]] on every 4th bit (bit_cnt[1:0]==3), in the same cycle.
REQ-017 SHALL transition RECV->DONE after bit 4*WORDS-1 is accepted; DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-018 SHALL return RECV->IDLE without asserting done if ena_in drops early; words already written are kept, the partial word is discarded, and the counters clear.
REQ-019 SHALL ignore bits arriving while ena_in stays high beyond 4*WORDS bits; the block waits in IDLE for ena_in low before a new frame may start.
REQ-020 SHALL start a new frame on the cycle after ena_in falls and rises again; back-to-back frames need at least one low cycle.
REQ-021 SHALL drive data_out <= store[rd_addr] one cycle after rd_addr is presented (1-cycle read latency); a read and a write to the same address in one cycle returns old data.
REQ-022 SHALL make rd_addr >= WORDS return 4'h0.
REQ-023 SHALL drive busy=1 only in RECV.

Reset
REQ-024 SHALL, while rst=1 at a clock edge: FSM->IDLE, bit counter=0, shift=0, done=0, busy=0, data_out=4'h0, all store entries=4'h0.
REQ-025 SHALL give rst priority over ena_in; reset mid-frame abandons the frame with no done pulse.
REQ-026 SHALL ignore frame bits in the first cycle after rst deasserts only if ena_in was already high (the wait-for-low rule of REQ-019 applies).

Configuration
REQ-027 SHALL add, when FRAME_ERR_EN is defined, output port frame_err  output  1, which pulses for one cycle on an early ena_in drop (REQ-018) or on the first over-length bit (REQ-019); frame_err resets to 0.
REQ-028 SHALL, when FRAME_ERR_EN is undefined, omit the frame_err port and its logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: key=0, 16 words 0..F sent serially → done pulses on cycle 65 after ena_in rise; rd_addr=5 gives data_out=4'h5 one cycle later.
REQ-030 SHALL cover: key=1, data_enc = ~bits of word pattern A,5,... → store holds 4'hA at addr 0 and 4'h5 at addr 1.
REQ-031 SHALL cover: ena_in drops after 10 bits → no done; addr 0,1 hold their words; addr 2 unchanged (4'h0 after reset); frame_err pulses when enabled.
REQ-032 SHALL cover: ena_in high for 70 bits → done once at bit 64; bits 65-70 ignored; store unchanged by them; frame_err pulses once when enabled.
REQ-033 SHALL cover: rst asserted at bit 30 → busy=0, data_out=0, all addresses read 4'h0, no done.
REQ-034 SHALL cover: WORDS=4, key=0, 16 bits 1,2,3,4 → done after bit 16; rd_addr=7 reads 4'h0.
